// File: rtl/window_addr_seq_if.sv
// Parameter/handshake bundle for window_addr_seq.
// rev_addr_out exists only when REVERSE_ADDR_EN is defined.
interface window_addr_seq_if;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WS_W   = 7;
  localparam int unsigned R_W    = 6;
  localparam int unsigned Q_W    = 4;

  logic              start_decode;
  logic [ADDR_W-1:0] BLOCK_SIZE;
  logic [WS_W-1:0]   window_size;
  logic [R_W-1:0]    r;
  logic [Q_W-1:0]    q_up;
  logic              addr_ready;

  logic              addr_valid;
  logic [ADDR_W-1:0] addr_out;
`ifdef REVERSE_ADDR_EN
  logic [ADDR_W-1:0] rev_addr_out;
`endif
  logic [Q_W-1:0]    win_idx;
  logic              win_first;
  logic              win_last;
  logic              busy;
  logic              done;

  modport master (
    output start_decode, BLOCK_SIZE, window_size, r, q_up, addr_ready,
    input
`ifdef REVERSE_ADDR_EN
           rev_addr_out,
`endif
           addr_valid, addr_out, win_idx, win_first, win_last, busy, done
  );

  modport slave (
    input  start_decode, BLOCK_SIZE, window_size, r, q_up, addr_ready,
    output
`ifdef REVERSE_ADDR_EN
           rev_addr_out,
`endif
           addr_valid, addr_out, win_idx, win_first, win_last, busy, done
  );
endinterface

// File: rtl/window_addr_seq.sv
// Windowed address sequencer: walks q_up windows of window_size (last one r if r!=0).
// Define REVERSE_ADDR_EN to add the registered backward address rev_addr_out.
module window_addr_seq (
  input  logic             clk,
  input  logic             reset,
  window_addr_seq_if.slave bus
);
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WS_W   = 7;
  localparam int unsigned R_W    = 6;
  localparam int unsigned Q_W    = 4;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] block_size_q;
  logic [WS_W-1:0]   window_size_q;
  logic [R_W-1:0]    r_q;
  logic [Q_W-1:0]    q_up_q;

  logic [Q_W-1:0]    idx;
  logic [WS_W-1:0]   offset;
  logic [ADDR_W-1:0] win_base;

  logic              addr_valid_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic              win_first_q;
  logic              win_last_q;
  logic              busy_q;
  logic              done_q;
`ifdef REVERSE_ADDR_EN
  logic [ADDR_W-1:0] rev_addr_q;
`endif

  logic              xfer_c;
  logic              at_last_c;
  logic              final_win_c;
  logic              step_c;
  logic              stop_c;
  logic [WS_W-1:0]   cur_len_c;
  logic [WS_W-1:0]   len_n_c;
  logic [Q_W-1:0]    idx_n_c;
  logic [WS_W-1:0]   offset_n_c;
  logic [ADDR_W-1:0] base_n_c;

  // Sub-block length is captured but the address walk itself never needs it.
  logic unused_block_size;
  assign unused_block_size = ^block_size_q;

  // The final window is shortened to r when a remainder is present.
  function automatic logic [WS_W-1:0] win_len(input logic [Q_W-1:0] i);
    if ((r_q != '0) && (i == q_up_q - Q_W'(1))) return WS_W'(r_q);
    return window_size_q;
  endfunction

  assign cur_len_c   = win_len(idx);
  assign at_last_c   = (offset == cur_len_c - WS_W'(1));
  assign final_win_c = (idx == q_up_q - Q_W'(1));
  assign xfer_c      = (state == RUN) && addr_valid_q && bus.addr_ready;
  assign step_c      = ((state == LOAD) && (q_up_q != '0)) || (xfer_c && !(at_last_c && final_win_c));
  assign stop_c      = ((state == LOAD) && (q_up_q == '0)) || (xfer_c && at_last_c && final_win_c);

  // Next position: restart in LOAD, roll into the next window without a bubble.
  always_comb begin
    idx_n_c    = idx;
    offset_n_c = offset + WS_W'(1);
    base_n_c   = win_base;
    if (state == LOAD) begin
      idx_n_c    = '0;
      offset_n_c = '0;
      base_n_c   = '0;
    end else if (at_last_c) begin
      idx_n_c    = idx + Q_W'(1);
      offset_n_c = '0;
      base_n_c   = win_base + ADDR_W'(window_size_q);
    end
  end

  assign len_n_c = win_len(idx_n_c);

  // Control FSM: parameter capture, busy and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      block_size_q  <= '0;
      window_size_q <= '0;
      r_q           <= '0;
      q_up_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_decode) begin
            block_size_q  <= bus.BLOCK_SIZE;
            window_size_q <= bus.window_size;
            r_q           <= bus.r;
            q_up_q        <= bus.q_up;
            busy_q        <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (q_up_q != '0) begin
            state <= RUN;
          end else begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        RUN: begin
          if (stop_c) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Position counters and registered address/flag outputs; held when no transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      offset       <= '0;
      win_base     <= '0;
      addr_valid_q <= 1'b0;
      addr_out_q   <= '0;
      win_first_q  <= 1'b0;
      win_last_q   <= 1'b0;
`ifdef REVERSE_ADDR_EN
      rev_addr_q   <= '0;
`endif
    end else if (step_c) begin
      idx          <= idx_n_c;
      offset       <= offset_n_c;
      win_base     <= base_n_c;
      addr_valid_q <= 1'b1;
      addr_out_q   <= base_n_c + ADDR_W'(offset_n_c);
      win_first_q  <= (offset_n_c == '0);
      win_last_q   <= (offset_n_c == len_n_c - WS_W'(1));
`ifdef REVERSE_ADDR_EN
      rev_addr_q   <= base_n_c + ADDR_W'(len_n_c) - ADDR_W'(1) - ADDR_W'(offset_n_c);
`endif
    end else if (stop_c) begin
      idx          <= '0;
      offset       <= '0;
      win_base     <= '0;
      addr_valid_q <= 1'b0;
      addr_out_q   <= '0;
      win_first_q  <= 1'b0;
      win_last_q   <= 1'b0;
`ifdef REVERSE_ADDR_EN
      rev_addr_q   <= '0;
`endif
    end
  end

  assign bus.addr_valid = addr_valid_q;
  assign bus.addr_out   = addr_out_q;
  assign bus.win_idx    = idx;
  assign bus.win_first  = win_first_q;
  assign bus.win_last   = win_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef REVERSE_ADDR_EN
  assign bus.rev_addr_out = rev_addr_q;
`endif

endmodule

// File: doc/window_addr_seq.md
WINDOW_ADDR_SEQ -- requirements
Module: window_addr_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-high.
- start_decode  in  1  single-cycle pulse; parameter bus valid this cycle.
- BLOCK_SIZE  in  10  sub-block length per parallel unit.
- window_size  in  7  nominal window length (1..64).
- r  in  6  remainder length of last window; 0 = full window.
- q_up  in  4  number of windows (0..15).
- addr_ready  in  1  consumer accepts addr_out.
- addr_valid  out  1  addr_out/flags valid.
- addr_out  out  10  forward address within sub-block.
- rev_addr_out  out  10  backward address within window (REVERSE_ADDR_EN only).
- win_idx  out  4  current window index.
- win_first  out  1  first address of a window.
- win_last  out  1  last address of a window.
- busy  out  1  high in LOAD and RUN.
- done  out  1  single-cycle completion pulse.

Function
REQ-002 The FSM SHALL have states IDLE, LOAD, RUN, DONE; reset state is IDLE.
REQ-003 In IDLE, start_decode=1 SHALL capture BLOCK_SIZE, window_size, r, q_up into registers and enter LOAD; start_decode in any other state SHALL be ignored.
REQ-004 LOAD SHALL last exactly one cycle: clear win_idx, offset, win_base; go to RUN if captured q_up!=0, else to DONE.
REQ-005 Window length SHALL be window_size, except the window with win_idx==q_up-1 and r!=0, whose length is r.
REQ-006 In RUN, addr_valid SHALL be 1 and addr_out SHALL equal win_base+offset (10-bit, modulo 1024).
REQ-007 A transfer occurs when addr_valid and addr_ready are both 1; without a transfer, all outputs SHALL hold.
REQ-008 On a transfer with offset < window length-1, offset SHALL increment by 1.
REQ-009 On a transfer at the last offset of a non-final window, the block SHALL clear offset, add window_size to win_base, and increment win_idx; there SHALL be no bubble cycle.
REQ-010 On a transfer at the last offset of the final window, the FSM SHALL enter DONE.
REQ-011 win_first SHALL be (offset==0) and win_last SHALL be (offset==window length-1); both are gated by addr_valid.
REQ-012 win_base SHALL be formed by accumulation; no multiplier.
REQ-013 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-014 First addr_valid SHALL occur 2 cycles after the start_decode cycle (IDLE->LOAD->RUN).
REQ-015 busy SHALL be 1 in LOAD and RUN, and 0 in IDLE and DONE.

Reset
REQ-016 When reset=1, regardless of clock, the FSM SHALL go to IDLE and all outputs and captured registers SHALL be 0.
REQ-017 Reset asserted mid-RUN SHALL abandon the block; after release, no output SHALL be asserted until a new start_decode.

Configuration
REQ-018 Macro REVERSE_ADDR_EN: when defined, rev_addr_out SHALL equal win_base+window length-1-offset, registered alongside addr_out.
REQ-019 When REVERSE_ADDR_EN is undefined, the rev_addr_out port SHALL be absent and no reverse-address logic SHALL be synthesized.

Verification
REQ-020 BLOCK_SIZE=256, window_size=64, r=0, q_up=4, addr_ready=1 -> addr_out 0..255 on consecutive cycles; win_last at 63,127,191,255; done 1 cycle after the final transfer.
REQ-021 BLOCK_SIZE=200, window_size=64, r=8, q_up=4 -> final window win_idx=3 produces addr_out 192..199; win_last at 199; total 200 transfers.
REQ-022 Same stimulus as REQ-020 with addr_ready toggling 1,0,0,1,... -> same address sequence with no skips or duplicates; outputs held while addr_ready=0.
REQ-023 q_up=0 -> addr_valid never asserted; done pulses 2 cycles after start_decode.
REQ-024 Reset pulsed at addr_out=100 of the REQ-020 run -> all outputs 0 immediately; a second start_decode restarts at addr_out=0.
REQ-025 With REVERSE_ADDR_EN defined and the REQ-021 stimulus -> rev_addr_out=63 at addr_out=0, and 199 at addr_out=192.
